debounced_logic_gate: RTL and testbench

//   Parametrised N-input gate for board switches/buttons driving an LED.

---
 rtl/debounced_logic_gate.sv | 118 +++++++++++
 tb/tb_debounced_logic_gate.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_logic_gate.sv
// Per-channel 2-FF synchroniser and debouncer feeding a runtime-selectable N-input gate (AND/OR/XOR/NAND).
// Define LOGIC_GATE_EDGE_COUNT_EN to add edge_count, a saturating count of out_gate rising edges.
module debounced_logic_gate #(
   parameter int N_INPUTS        = 3,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_INPUTS-1:0] in_raw,
   input  logic [1:0]          mode,
   output logic [N_INPUTS-1:0] in_stable,
   output logic                out_gate,
   output logic                out_changed
`ifdef LOGIC_GATE_EDGE_COUNT_EN
   ,
   output logic [15:0]         edge_count
`endif
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] MODE_AND  = 2'b00;
   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_XOR  = 2'b10;
   localparam logic [1:0] MODE_NAND = 2'b11;

   logic [N_INPUTS-1:0] sync1_q;
   logic [N_INPUTS-1:0] sync2_q;
   logic [N_INPUTS-1:0] stable_q;
   logic [N_INPUTS-1:0] stable_d;
   logic [CNT_W-1:0]    cnt_q [N_INPUTS];
   logic [CNT_W-1:0]    cnt_d [N_INPUTS];
   logic                gate_q;
   logic                gate_d;
   logic                changed_q;
   logic                changed_d;

   // A channel's counter only runs while its synchronised input disagrees with the accepted value.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
      stable_d = stable_q;
      for (int i = 0; i < N_INPUTS; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      gate_d = 1'b0;
      unique case (mode)
         MODE_AND:  gate_d = &stable_q;
         MODE_OR:   gate_d = |stable_q;
         MODE_XOR:  gate_d = ^stable_q;
         MODE_NAND: gate_d = ~&stable_q;
         default:   gate_d = 1'b0;
      endcase
      changed_d = (gate_d != gate_q);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         gate_q    <= 1'b0;
         changed_q <= 1'b0;
         // NOTE: the counter array is reset too, so a debounce in progress is dropped by reset.
         for (int i = 0; i < N_INPUTS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= in_raw;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         gate_q    <= gate_d;
         changed_q <= changed_d;
         for (int i = 0; i < N_INPUTS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign in_stable   = stable_q;
   assign out_gate    = gate_q;
   assign out_changed = changed_q;

`ifdef LOGIC_GATE_EDGE_COUNT_EN
   logic [15:0] edge_cnt_q;
   logic [15:0] edge_cnt_d;

   // Counts on the same edge that out_gate rises; holds at all-ones.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      if (gate_d && !gate_q && (edge_cnt_q != 16'hFFFF)) begin
         edge_cnt_d = edge_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         edge_cnt_q <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign edge_count = edge_cnt_q;
`endif

endmodule

// File: tb/tb_debounced_logic_gate.sv
// Bench for debounced_logic_gate (N_INPUTS=3, DEBOUNCE_CYCLES=4): vector table, hand sequences, random run vs model.
// The edge_count checks are compiled in only when LOGIC_GATE_EDGE_COUNT_EN is defined.
module tb_debounced_logic_gate;

   localparam int N = 3;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] in_raw;
   logic [1:0]   mode;
   logic [N-1:0] in_stable;
   logic         out_gate;
   logic         out_changed;
`ifdef LOGIC_GATE_EDGE_COUNT_EN
   logic [15:0]  edge_count;
`endif

   debounced_logic_gate #(
      .N_INPUTS        (N),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_raw      (in_raw),
      .mode        (mode),
      .in_stable   (in_stable),
      .out_gate    (out_gate),
`ifdef LOGIC_GATE_EDGE_COUNT_EN
      .edge_count  (edge_count),
`endif
      .out_changed (out_changed)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: an input is accepted once its last D synchronised samples all disagree with the accepted value.
   logic [N-1:0] m_stable;
   logic         m_gate;
   logic         m_chg;
   logic [15:0]  m_edge;
   logic [N-1:0] m_sync[$];
   logic [N-1:0] m_hist[$];

   function automatic logic gate_ref(input logic [N-1:0] v, input logic [1:0] md);
      int ones;
      ones = $countones(v);
      case (md)
         2'd0:    return ones == N;
         2'd1:    return ones != 0;
         2'd2:    return (ones % 2) == 1;
         default: return ones != N;
      endcase
   endfunction

   task automatic model_edge();
      logic         nxt;
      logic [N-1:0] s;
      bit           all_diff;
      if (!rst_n) begin
         m_stable = '0;
         m_gate   = 1'b0;
         m_chg    = 1'b0;
         m_edge   = '0;
         m_sync.delete();
         m_sync.push_back('0);
         m_sync.push_back('0);
         m_hist.delete();
      end else begin
         nxt   = gate_ref(m_stable, mode);
         m_chg = (nxt != m_gate);
         if (nxt && !m_gate && m_edge != 16'hFFFF) m_edge = m_edge + 16'd1;
         m_gate = nxt;
         s = m_sync.pop_front();
         m_sync.push_back(in_raw);
         m_hist.push_back(s);
         if (m_hist.size() > D) void'(m_hist.pop_front());
         for (int ch = 0; ch < N; ch++) begin
            if (m_hist.size() == D) begin
               all_diff = 1'b1;
               foreach (m_hist[k]) if (m_hist[k][ch] == m_stable[ch]) all_diff = 1'b0;
               if (all_diff) m_stable[ch] = ~m_stable[ch];
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_outputs(input string tag, input logic [N-1:0] st, input logic g, input logic c);
      check({tag, "_stable"},  32'(in_stable),   32'(st));
      check({tag, "_gate"},    32'(out_gate),    32'(g));
      check({tag, "_changed"}, 32'(out_changed), 32'(c));
   endtask

   typedef struct {
      string        name;
      logic [N-1:0] raw;
      logic [1:0]   md;
      int           n_ticks;
      logic [N-1:0] st;
      logic         gate;
      logic         chg;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"t2_wait",      3'b111, 2'b00, 5, 3'b000, 1'b0, 1'b0};
      vecs[1]  = '{"t2_stable",    3'b111, 2'b00, 1, 3'b111, 1'b0, 1'b0};
      vecs[2]  = '{"t2_gate",      3'b111, 2'b00, 1, 3'b111, 1'b1, 1'b1};
      vecs[3]  = '{"t2_pulse_end", 3'b111, 2'b00, 1, 3'b111, 1'b1, 1'b0};
      vecs[4]  = '{"t3_glitch",    3'b110, 2'b00, 3, 3'b111, 1'b1, 1'b0};
      vecs[5]  = '{"t3_hold",      3'b111, 2'b00, 8, 3'b111, 1'b1, 1'b0};
      vecs[6]  = '{"t4_settle",    3'b101, 2'b00, 7, 3'b101, 1'b0, 1'b1};
      vecs[7]  = '{"t4_quiet",     3'b101, 2'b00, 1, 3'b101, 1'b0, 1'b0};
      vecs[8]  = '{"t4_or",        3'b101, 2'b01, 1, 3'b101, 1'b1, 1'b1};
      vecs[9]  = '{"t4_xor",       3'b101, 2'b10, 1, 3'b101, 1'b0, 1'b1};
      vecs[10] = '{"t4_nand",      3'b101, 2'b11, 1, 3'b101, 1'b1, 1'b1};
      vecs[11] = '{"t4_and",       3'b101, 2'b00, 1, 3'b101, 1'b0, 1'b1};

      // Reset state
      rst_n  = 1'b0;
      in_raw = '0;
      mode   = 2'b00;
      ticks(3);
      check_outputs("t1_reset", 3'b000, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Latency, glitch rejection and mode stepping from the vector table
      foreach (vecs[v]) begin
         in_raw = vecs[v].raw;
         mode   = vecs[v].md;
         for (int t = 1; t <= vecs[v].n_ticks; t++) begin
            tick();
            if (t < vecs[v].n_ticks && !vecs[v].chg)
               check({vecs[v].name, "_nopulse"}, 32'(out_changed), 32'd0);
         end
         check_outputs(vecs[v].name, vecs[v].st, vecs[v].gate, vecs[v].chg);
      end

      // Mode change lands on the same edge as a new in_stable: NAND(111)=0, so no pulse
      in_raw = 3'b111;
      ticks(6);
      check_outputs("sim_pre", 3'b111, 1'b0, 1'b0);
      mode = 2'b11;
      tick();
      check_outputs("sim_both", 3'b111, 1'b0, 1'b0);

      // First edge after reset with NAND drives out_gate high with a pulse
      rst_n  = 1'b0;
      in_raw = '0;
      ticks(2);
      check_outputs("nand_rst", 3'b000, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      check_outputs("nand_first", 3'b000, 1'b1, 1'b1);
      tick();
      check_outputs("nand_second", 3'b000, 1'b1, 1'b0);

      // Reset in the middle of a debounce discards it
      rst_n = 1'b0;
      mode  = 2'b00;
      ticks(2);
      rst_n  = 1'b1;
      in_raw = 3'b111;
      ticks(3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         tick();
         check("t5_discarded", 32'(in_stable), 32'd0);
      end
      tick();
      check("t5_accepted", 32'(in_stable), 32'(3'b111));

`ifdef LOGIC_GATE_EDGE_COUNT_EN
      rst_n  = 1'b0;
      in_raw = '0;
      ticks(2);
      check("t6_reset", 32'(edge_count), 32'd0);
      rst_n = 1'b1;
      for (int r = 0; r < 5; r++) begin
         in_raw = 3'b111;
         ticks(8);
         in_raw = 3'b000;
         ticks(8);
      end
      check("t6_five", 32'(edge_count), 32'd5);
      force dut.edge_cnt_q = 16'hFFFF;
      m_edge = 16'hFFFF;
      tick();
      release dut.edge_cnt_q;
      in_raw = 3'b111;
      ticks(8);
      check("t6_saturate", 32'(edge_count), 32'hFFFF);
      check("t6_rise", 32'(out_gate), 32'd1);
`endif

      // Random run against the reference model
      for (int c = 0; c < 3000; c++) begin
         int idx;
         if ($urandom_range(0, 5) == 0) begin
            idx = $urandom_range(0, N - 1);
            in_raw[idx] = ~in_raw[idx];
         end
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         rst_n = ($urandom_range(0, 399) != 0);
         tick();
         check_outputs("rnd", m_stable, m_gate, m_chg);
`ifdef LOGIC_GATE_EDGE_COUNT_EN
         check("rnd_edge_count", 32'(edge_count), 32'(m_edge));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
